// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   INS_W         : instruction word width
//   PC_W          : stored PC field width (queue WIDTH may be up to this)
//   RESET_PC      : architectural reset vector
//   fetch_entry_t : one fetched {pc, ins} pair as held in fetch storage
package cpu_pkg;

  localparam int unsigned INS_W    = 32;
  localparam int unsigned PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of {pc, ins} pairs with valid/ready handshakes on both sides
// and a flush that empties the queue on the next edge.
//   clk, rst                   : clock, asynchronous active-low reset
//   in_valid/in_ready          : enqueue handshake, in_pc/in_ins carry the pair
//   out_valid/out_ready        : dequeue handshake, head shown on out_pc/out_ins
//   out_fault                  : head instruction is not a 32-bit encoding
//   flush                      : discard all entries (beats any enqueue/dequeue)
//   count                      : number of valid entries
module inst_queue
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,  // must not exceed PC_W
  parameter int unsigned DEPTH = 4    // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_pc,
  input  logic [INS_W-1:0]           in_ins,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_pc,
  output logic [INS_W-1:0]           out_ins,
  output logic                       out_fault,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  fetch_entry_t    head_entry;

  // rst gates in_ready so nothing is offered acceptance while held in reset.
  assign in_ready  = rst && (count_q < Full) && !flush;
  assign out_valid = (count_q != '0) && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  assign head_entry = mem_q[head_q];
  assign out_pc     = out_valid ? WIDTH'(head_entry.pc) : '0;
  assign out_ins    = out_valid ? head_entry.ins : '0;
  assign out_fault  = out_valid && (head_entry.ins[1:0] != 2'b11);

  // DEPTH is a power of two, so pointers wrap naturally at PtrW bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset; only pointers and count clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) mem_q[tail_q] <= '{pc: PC_W'(in_pc), ins: in_ins};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: scoreboard of expected {pc, ins} pairs,
// pushed on accepted offers and popped when the queue delivers its head.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ins;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ins;
  logic        out_fault;
  logic        flush;
  logic [2:0]  count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  inst_queue #(
    .WIDTH(32),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_ins   (in_ins),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_ins  (out_ins),
    .out_fault(out_fault),
    .flush    (flush),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: evaluate handshakes at the negedge, then advance past the posedge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_delivery", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_pc", 64'(out_pc), 64'(e.pc));
          check("sb_ins", 64'(out_ins), 64'(e.ins));
          check("sb_fault", 64'(out_fault), 64'(e.ins[1:0] != 2'b11));
        end
      end
      if (in_valid && in_ready) sb.push_back('{pc: in_pc, ins: in_ins});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ins   = ins;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_pc = '0; in_ins = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    rst = 1'b1;
    #1;
    check("idle_count", 64'(count), 64'd0);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_out_ins", 64'(out_ins), 64'd0);

    // Single pass, first-entry latency of one edge
    enq(32'h8000_0000, 32'h0000_0413);
    check("single_out_valid", 64'(out_valid), 64'd1);
    check("single_out_pc", 64'(out_pc), 64'h8000_0000);
    check("single_out_ins", 64'(out_ins), 64'h0000_0413);
    check("single_out_fault", 64'(out_fault), 64'd0);
    check("single_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("single_drained", 64'(count), 64'd0);

    // Fill, hold a fifth offer, drain in order
    for (int i = 0; i < 4; i++) enq(32'h8000_0000 + 32'(4 * i), 32'h0000_0013 + 32'(i << 7));
    check("full_count", 64'(count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    enq(32'h8000_0010, 32'h0000_0093);
    check("full_held_count", 64'(count), 64'd4);
    out_ready = 1'b1;
    repeat (4) step();
    out_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_sb_empty", 64'(sb.size()), 64'd0);

    // Simultaneous traffic across the pointer wrap
    enq(32'h8000_1000, 32'h0000_0033);
    enq(32'h8000_1004, 32'h0000_0033);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc  = 32'h8000_1008 + 32'(4 * i);
      in_ins = 32'h0000_0033;
      step();
      check("wrap_count", 64'(count), 64'd2);
    end
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b0;
    check("wrap_drained", 64'(count), 64'd0);

    // Flush colliding with enqueue and dequeue
    for (int i = 0; i < 3; i++) enq(32'h8000_2000 + 32'(4 * i), 32'h0000_0013);
    check("pre_flush_count", 64'(count), 64'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_pc = 32'h8000_200C; in_ins = 32'h0000_0013;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("post_flush_count", 64'(count), 64'd0);
    check("post_flush_out_valid", 64'(out_valid), 64'd0);
    repeat (2) step();
    out_ready = 1'b0;

    // Fault flag, then asynchronous reset mid-cycle
    enq(32'h8000_3000, 32'h0000_0001);
    check("fault_flag", 64'(out_fault), 64'd1);
    enq(32'h8000_3004, 32'h0000_0013);
    check("fault_count", 64'(count), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_fault", 64'(out_fault), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rerelease_in_ready", 64'(in_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
